// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//
// Round-robin scheduler and bit-serial sequencer. It shares one external
// full_adder cell among NREQ requesters.
//
// Flow for each operation:
//   - Accept one WIDTH-bit add request.
//   - Drive the adder LSB first, one bit per clock.
//   - Collect sum/carry back from the adder.
//   - Return the result and the requester id over a valid/ready channel.
//
// Ports:
//   clk, rst_n            system clock (rising edge), async active-low reset
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot or zero
//   req_a, req_b          operands, requester i in bits [i*WIDTH +: WIDTH]
//   req_cin               per-requester carry-in
//   fa_a, fa_b, fa_c      to the shared full_adder inputs
//   fa_sum, fa_carry      from the shared full_adder (combinational)
//   rsp_valid/rsp_ready   result handshake
//   rsp_id                requester that was served
//   rsp_sum, rsp_cout     WIDTH-bit sum and final carry-out
//   rsp_ovf               signed overflow (only with SERIAL_ADD_OVF_EN)
//
// Optional feature: define SERIAL_ADD_OVF_EN to add the rsp_ovf output.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | arbitrating; req_ready offered to the next valid requester
// RUN   | one operand bit per clock through the shared full_adder
// DONE  | result presented on rsp_*; waiting for rsp_ready

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic                  fa_a,
    output logic                  fa_b,
    output logic                  fa_c,
    input  logic                  fa_sum,
    input  logic                  fa_carry,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   rr_ptr_nxt;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   grant_id;
    logic [NREQ-1:0]  grant;
    logic             grant_any;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    // Rotating priority search: the first valid requester found from rr_ptr
    // upward wins. Indices wrap at NREQ, so NREQ does not need to be a
    // power of two.
    always_comb begin
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

    assign grant_any  = |grant;
    assign rr_ptr_nxt = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
    assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_c      = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                // rst_n gate keeps req_ready low while reset is asserted,
                // even though the grant search itself is combinational.
                if (rst_n) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fa_a = a_q[bit_cnt];
                fa_b = b_q[bit_cnt];
                fa_c = carry_q;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            bit_cnt <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            id_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        a_q     <= req_a[int'(grant_id)*WIDTH +: WIDTH];
                        b_q     <= req_b[int'(grant_id)*WIDTH +: WIDTH];
                        carry_q <= req_cin[grant_id];
                        id_q    <= grant_id;
                        bit_cnt <= '0;
                        rr_ptr  <= rr_ptr_nxt;
                    end
                end
                RUN: begin
                    sum_q[bit_cnt] <= fa_sum;
                    carry_q        <= fa_carry;
                    bit_cnt        <= bit_cnt + CW'(1);
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is still the carry into the MSB here.
                    if (last_bit) begin
                        ovf_q <= carry_q ^ fa_carry;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    // carry_q is left holding the carry out of the MSB once RUN finishes.
    assign rsp_id   = id_q;
    assign rsp_sum  = sum_q;
    assign rsp_cout = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign rsp_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           fa_a, fa_b, fa_c, fa_sum, fa_carry;
    logic           rsp_valid, rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic           rsp_ovf;
`endif

    serial_add_ctrl #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_sum(fa_sum), .fa_carry(fa_carry),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
`ifdef SERIAL_ADD_OVF_EN
        , .rsp_ovf(rsp_ovf)
`endif
    );

    // The shared full_adder cell
    assign fa_sum   = fa_a ^ fa_b ^ fa_c;
    assign fa_carry = (fa_a & fa_b) | (fa_c & (fa_a ^ fa_b));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    logic [W-1:0] sa [N];
    logic [W-1:0] sb [N];
    logic         sc [N];

    typedef struct {
        int       id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic     cin;
        logic [W-1:0] sum;
        logic     cout;
        logic     ovf;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        sa[id] = a; sb[id] = b; sc[id] = c;
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_cin[id] = c;
    endtask

    function automatic int first_valid(input logic [N-1:0] mask, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Reference: plain wide arithmetic plus the sign rule for overflow
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] s;
        logic       ov;
        s  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return {ov, s};
    endfunction

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Entered at posedge+1 with request inputs already applied.
    task automatic run_one(input int eid, input logic [W-1:0] esum, input logic ecout,
                           input logic eovf, input int stall, input logic [N-1:0] post_mask,
                           input bit scramble);
        int lat;
        logic [W-1:0] held;
        #1;
        check("req_ready_grant", req_ready, 32'(1) << eid);
        @(posedge clk); #1;
        ptr_m = (eid + 1) % N;
        req_valid = post_mask;
        if (scramble) begin
            for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
        end
        wait_rsp(lat);
        check("latency", lat, W);
        check("rsp_sum", rsp_sum, esum);
        check("rsp_cout", rsp_cout, ecout);
        check("rsp_id", rsp_id, eid);
`ifdef SERIAL_ADD_OVF_EN
        check("rsp_ovf", rsp_ovf, eovf);
`endif
        held = rsp_sum;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            check("stall_valid", rsp_valid, 1);
            check("stall_sum", rsp_sum, held);
            check("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;
        check("rsp_valid_drop", rsp_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int eid, grants, rsps, last_t, cyc;
        logic [W+1:0] m;
        logic [W+1:0] expq [$];
        logic [1:0]   idq [$];
        logic [N-1:0] mask;

        vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{2, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, '0, '0, 1'b0);
        #12;
        check("rst_req_ready", req_ready, 0);
        check("rst_fa", {fa_a, fa_b, fa_c}, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_sum", rsp_sum, 0);
        check("rst_rsp_cout", rsp_cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_rsp_ovf", rsp_ovf, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            set_req(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].cin);
            req_valid = N'(1) << vecs[i].id;
            run_one(vecs[i].id, vecs[i].sum, vecs[i].cout, vecs[i].ovf, 0, '0, 1'b0);
        end

        // All requesters valid: round-robin order and accept spacing
        for (int i = 0; i < N; i++) set_req(i, W'(8'h11 * (i + 1)), W'(8'h2F + 8'h40 * i), 1'(i));
        rsp_ready = 1'b1;
        req_valid = '1;
        grants = 0; rsps = 0; last_t = 0; cyc = 0;
        #1;
        while (rsps < 5 && cyc < 200) begin
            if (req_ready != 0 && grants < 5) begin
                eid = first_valid(req_valid, ptr_m);
                check("rr_grant", req_ready, 32'(1) << eid);
                idq.push_back(2'(eid));
                expq.push_back(model(sa[eid], sb[eid], sc[eid]));
                if (grants > 0) check("accept_spacing", cyc - last_t, W + 2);
                last_t = cyc;
                grants++;
                ptr_m = (eid + 1) % N;
            end
            if (rsp_valid && idq.size() > 0) begin
                m = expq.pop_front();
                check("rr_rsp_id", rsp_id, idq.pop_front());
                check("rr_rsp_sum", {rsp_cout, rsp_sum}, m[W:0]);
                rsps++;
            end
            @(posedge clk); #1;
            cyc++;
            if (rsps == 5) req_valid = '0;
        end
        check("rr_grants", grants, 5);
        check("rr_rsps", rsps, 5);
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = '0;

        // Back-pressure in DONE with requester 1 waiting
        set_req(0, 8'h21, 8'h43, 1'b0);
        set_req(1, 8'h80, 8'h80, 1'b0);
        req_valid = 4'b0001;
        ptr_m = 1;
        run_one(0, 8'h64, 1'b0, 1'b0, 5, 4'b0010, 1'b0);
        req_valid = 4'b0010;
        run_one(1, 8'h00, 1'b1, 1'b1, 0, '0, 1'b0);

        // Reset in the middle of RUN
        set_req(2, 8'h08, 8'h00, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("rst_mid_grant", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) begin @(posedge clk); #1; end
        check("run_bit3_fa_a", fa_a, 1);
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", req_ready, 0);
        check("mid_rst_fa", {fa_a, fa_b, fa_c}, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_id, rsp_sum, rsp_cout}, 0);
        @(posedge clk); #1;
        check("mid_rst_no_rsp", rsp_valid, 0);
        rst_n = 1'b1;
        ptr_m = 0;
        #1;
        check("rst_ptr_zero", req_ready, 4'b0010);
        set_req(3, 8'hC3, 8'h5A, 1'b1);
        req_valid = 4'b1000;
        run_one(3, 8'h1E, 1'b1, 1'b0, 0, '0, 1'b0);

        // Randomized traffic against the arithmetic/round-robin model
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < N; i++) set_req(i, W'($urandom), W'($urandom), 1'($urandom));
            mask = N'($urandom_range(1, (1 << N) - 1));
            req_valid = mask;
            eid = first_valid(mask, ptr_m);
            m = model(sa[eid], sb[eid], sc[eid]);
            run_one(eid, m[W-1:0], m[W], m[W+1], $urandom_range(0, 2),
                    N'($urandom_range(0, (1 << N) - 1)), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
